// File: rtl/pair_dist_engine.sv
// Min/max pairwise |a-b| engine: loads N big-endian values from byte memory, scans all pairs, writes results back.
// Define PAIR_IDX_WR_EN to also write the four pair-index bytes after the two result magnitudes.
module pair_dist_engine #(
  parameter int N         = 32,
  parameter int W         = 16,
  parameter int SIGNED    = 1,
  parameter int AW        = 8,
  parameter int BASE_ADDR = 0,
  parameter int RES_ADDR  = 66
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 done,
  output logic                 busy,
  output logic [AW-1:0]        mem_addr,
  input  logic [7:0]           mem_rdata,
  output logic [7:0]           mem_wdata,
  output logic                 mem_wen,
  output logic [W-1:0]         min_dist,
  output logic [W-1:0]         max_dist,
  output logic [$clog2(N)-1:0] min_i,
  output logic [$clog2(N)-1:0] min_j,
  output logic [$clog2(N)-1:0] max_i,
  output logic [$clog2(N)-1:0] max_j
);

  localparam int B  = W / 8;
  localparam int IW = $clog2(N);
  localparam int L  = N * B;
`ifdef PAIR_IDX_WR_EN
  localparam int WB = 2 * B + 4;
`else
  localparam int WB = 2 * B;
`endif
  localparam int CW = $clog2(L + WB + 1);

  typedef enum logic [2:0] {IDLE_ST, LOAD_ST, SCAN_ST, WRITE_ST, DONE_ST} state_t;

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [IW-1:0]   j_r, j_s, k_r, k_s;
  logic [IW-1:0]   min_i_r, min_i_s, min_j_r, min_j_s;
  logic [IW-1:0]   max_i_r, max_i_s, max_j_r, max_j_s;
  logic [W-1:0]    min_dist_r, min_dist_s, max_dist_r, max_dist_s;
  logic [N*W-1:0]  cache_r;
  logic            start_q_r;
  logic            shift_s;
  logic            done_r, done_s, busy_r, busy_s, wen_r, wen_s;
  logic [AW-1:0]   addr_r, addr_s;
  logic [7:0]      wdata_r, wdata_s;
  logic [W-1:0]    dist_s;
  logic [WB*8-1:0] wr_vec_s;

  // Exact magnitude of a-b, evaluated one bit wider so the full 2^W-1 range survives.
  function automatic logic [W-1:0] abs_dist(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] ea;
    logic [W:0] eb;
    logic [W:0] d;
    ea = (SIGNED != 0) ? {a[W-1], a} : {1'b0, a};
    eb = (SIGNED != 0) ? {b[W-1], b} : {1'b0, b};
    d  = ea - eb;
    if (d[W]) begin
      d = (~d) + {{W{1'b0}}, 1'b1};
    end else begin
      d = d;
    end
    return d[W-1:0];
  endfunction

  // Value 0 is the first byte group read, so it ends up in the top W bits of the cache.
  assign dist_s = abs_dist(cache_r[(N - int'(j_r)) * W - 1 -: W],
                           cache_r[(N - int'(k_r)) * W - 1 -: W]);

`ifdef PAIR_IDX_WR_EN
  assign wr_vec_s = {min_dist_r, max_dist_r, 8'(min_i_r), 8'(min_j_r), 8'(max_i_r), 8'(max_j_r)};
`else
  assign wr_vec_s = {min_dist_r, max_dist_r};
`endif

  // Next-state, datapath updates and next values of the registered memory/handshake outputs.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    j_s        = j_r;
    k_s        = k_r;
    min_dist_s = min_dist_r;
    max_dist_s = max_dist_r;
    min_i_s    = min_i_r;
    min_j_s    = min_j_r;
    max_i_s    = max_i_r;
    max_j_s    = max_j_r;
    addr_s     = addr_r;
    wdata_s    = wdata_r;
    wen_s      = 1'b0;
    done_s     = 1'b0;
    shift_s    = 1'b0;
    case (state_r)
      IDLE_ST: begin
        if (start_q_r && !start) begin
          state_s    = LOAD_ST;
          cnt_s      = '0;
          min_dist_s = '1;
          max_dist_s = '0;
          min_i_s    = '0;
          min_j_s    = '0;
          max_i_s    = '0;
          max_j_s    = '0;
          addr_s     = AW'(BASE_ADDR);
        end else begin
          state_s = IDLE_ST;
        end
      end
      LOAD_ST: begin
        if (start) begin
          state_s = IDLE_ST;
        end else begin
          shift_s = 1'b1;
          if (cnt_r == CW'(L - 1)) begin
            state_s = SCAN_ST;
            cnt_s   = '0;
            j_s     = '0;
            k_s     = IW'(1);
          end else begin
            cnt_s  = cnt_r + CW'(1);
            addr_s = AW'(BASE_ADDR) + AW'(cnt_r) + AW'(1);
          end
        end
      end
      SCAN_ST: begin
        if (start) begin
          state_s = IDLE_ST;
        end else begin
          // Strict compares keep the earliest pair in scan order on ties.
          if (dist_s < min_dist_r) begin
            min_dist_s = dist_s;
            min_i_s    = j_r;
            min_j_s    = k_r;
          end else begin
            min_dist_s = min_dist_r;
          end
          if (dist_s > max_dist_r) begin
            max_dist_s = dist_s;
            max_i_s    = j_r;
            max_j_s    = k_r;
          end else begin
            max_dist_s = max_dist_r;
          end
          if (k_r == IW'(N - 1)) begin
            if (j_r == IW'(N - 2)) begin
              state_s = WRITE_ST;
              cnt_s   = '0;
            end else begin
              j_s = j_r + IW'(1);
              k_s = j_r + IW'(2);
            end
          end else begin
            k_s = k_r + IW'(1);
          end
        end
      end
      WRITE_ST: begin
        if (start) begin
          state_s = IDLE_ST;
        end else begin
          wen_s   = 1'b1;
          addr_s  = AW'(RES_ADDR) + AW'(cnt_r);
          wdata_s = wr_vec_s[(WB - int'(cnt_r)) * 8 - 1 -: 8];
          if (cnt_r == CW'(WB - 1)) begin
            state_s = DONE_ST;
            cnt_s   = '0;
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end
      end
      DONE_ST: begin
        if (start) begin
          state_s = IDLE_ST;
        end else begin
          done_s = 1'b1;
        end
      end
      default: begin
        state_s = IDLE_ST;
      end
    endcase
    busy_s = (state_s == LOAD_ST) || (state_s == SCAN_ST) || (state_s == WRITE_ST) || wen_s;
  end

  // State, counters, results and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE_ST;
      cnt_r      <= '0;
      j_r        <= '0;
      k_r        <= '0;
      start_q_r  <= 1'b0;
      min_dist_r <= '1;
      max_dist_r <= '0;
      min_i_r    <= '0;
      min_j_r    <= '0;
      max_i_r    <= '0;
      max_j_r    <= '0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
      wen_r      <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= '0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      j_r        <= j_s;
      k_r        <= k_s;
      start_q_r  <= start;
      min_dist_r <= min_dist_s;
      max_dist_r <= max_dist_s;
      min_i_r    <= min_i_s;
      min_j_r    <= min_j_s;
      max_i_r    <= max_i_s;
      max_j_r    <= max_j_s;
      done_r     <= done_s;
      busy_r     <= busy_s;
      wen_r      <= wen_s;
      addr_r     <= addr_s;
      wdata_r    <= wdata_s;
    end
  end

  // Operand cache: one byte shifted in per LOAD cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cache_r <= '0;
    end else if (shift_s) begin
      cache_r <= {cache_r[N*W-9:0], mem_rdata};
    end else begin
      cache_r <= cache_r;
    end
  end

  assign done      = done_r;
  assign busy      = busy_r;
  assign mem_wen   = wen_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign min_dist  = min_dist_r;
  assign max_dist  = max_dist_r;
  assign min_i     = min_i_r;
  assign min_j     = min_j_r;
  assign max_i     = max_i_r;
  assign max_j     = max_j_r;

endmodule

// File: tb/tb_pair_dist_engine.sv
// Bench for pair_dist_engine: three instances (N=32 signed, N=4 signed, N=4 unsigned) on private byte memories,
// checked against a brute-force pairwise reference model.
module tb_pair_dist_engine;

  localparam int NI  = 3;
  localparam int RES = 66;
`ifdef PAIR_IDX_WR_EN
  localparam int WB = 8;
`else
  localparam int WB = 4;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start_s [NI];
  logic       done_a  [NI];
  logic       busy_a  [NI];
  logic       wen_a   [NI];
  logic [7:0] addr_a  [NI];
  logic [7:0] wdata_a [NI];
  logic [7:0] rdata_a [NI];
  logic [15:0] mind_a [NI];
  logic [15:0] maxd_a [NI];
  logic [7:0] mi_a [NI];
  logic [7:0] mj_a [NI];
  logic [7:0] xi_a [NI];
  logic [7:0] xj_a [NI];

  logic [7:0] mem [NI][256];
  int         bad_wr [NI] = '{0, 0, 0};
  logic       ld_en = 1'b0;
  int         ld_g = 0;
  logic [7:0] ld_a = 8'd0;
  logic [7:0] ld_d = 8'd0;

  logic [15:0] vals [32];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int GN  = (gi == 0) ? 32 : 4;
    localparam int GS  = (gi == 2) ? 0 : 1;
    localparam int GIW = $clog2(GN);
    logic [GIW-1:0] mi_w, mj_w, xi_w, xj_w;
    pair_dist_engine #(.N(GN), .W(16), .SIGNED(GS), .AW(8), .BASE_ADDR(0), .RES_ADDR(RES)) u_dut (
      .clk(clk), .reset(rst), .start(start_s[gi]), .done(done_a[gi]), .busy(busy_a[gi]),
      .mem_addr(addr_a[gi]), .mem_rdata(rdata_a[gi]), .mem_wdata(wdata_a[gi]), .mem_wen(wen_a[gi]),
      .min_dist(mind_a[gi]), .max_dist(maxd_a[gi]),
      .min_i(mi_w), .min_j(mj_w), .max_i(xi_w), .max_j(xj_w));
    assign rdata_a[gi] = mem[gi][addr_a[gi]];
    assign mi_a[gi] = 8'(mi_w);
    assign mj_a[gi] = 8'(mj_w);
    assign xi_a[gi] = 8'(xi_w);
    assign xj_a[gi] = 8'(xj_w);
  end

  // Byte memories: bench preload port plus DUT writes, flagging any write outside the result window.
  always @(posedge clk) begin
    if (ld_en) mem[ld_g][ld_a] <= ld_d;
    for (int g = 0; g < NI; g++) begin
      if (wen_a[g]) begin
        mem[g][addr_a[g]] <= wdata_a[g];
        if (int'(addr_a[g]) < RES || int'(addr_a[g]) >= RES + WB) bad_wr[g] <= bad_wr[g] + 1;
      end
    end
  end

  function automatic int n_of(input int g);
    return (g == 0) ? 32 : 4;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: every unordered pair in scan order, plain integer arithmetic, strict compares.
  task automatic model(input int n, input bit sg, output int mn, output int mx,
                       output int mi, output int mj, output int xi, output int xj);
    int a, b, d;
    mn = 65535; mx = 0; mi = 0; mj = 0; xi = 0; xj = 0;
    for (int j = 0; j < n - 1; j++) begin
      for (int k = j + 1; k < n; k++) begin
        a = sg ? int'($signed(vals[j])) : int'(vals[j]);
        b = sg ? int'($signed(vals[k])) : int'(vals[k]);
        d = (a > b) ? a - b : b - a;
        if (d < mn) begin mn = d; mi = j; mj = k; end
        if (d > mx) begin mx = d; xi = j; xj = k; end
      end
    end
  endtask

  task automatic ld(input int g, input int a, input logic [7:0] d);
    ld_en = 1'b1; ld_g = g; ld_a = 8'(a); ld_d = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic load_vals(input int g);
    for (int i = 0; i < n_of(g); i++) begin
      ld(g, 2 * i, vals[i][15:8]);
      ld(g, 2 * i + 1, vals[i][7:0]);
    end
    for (int b = 0; b < WB; b++) ld(g, RES + b, 8'hEE);
  endtask

  task automatic set4(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
    vals[0] = a; vals[1] = b; vals[2] = c; vals[3] = d;
  endtask

  task automatic launch(input int g);
    start_s[g] = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    start_s[g] = 1'b0;
  endtask

  task automatic run_check(input int g, input string tag);
    int n, cyc, nwen, last_wen, mn, mx, mi, mj, xi, xj;
    bit seen;
    n = n_of(g);
    load_vals(g);
    launch(g);
    cyc = 0; nwen = 0; last_wen = 0; seen = 1'b0;
    while (cyc < 20000 && !seen) begin
      @(posedge clk); #1;
      cyc++;
      if (done_a[g]) seen = 1'b1;
      else if (wen_a[g]) begin nwen++; last_wen = cyc; end
    end
    check_val({tag, " done_seen"}, 32'(seen), 32'd1);
    check_val({tag, " latency"}, 32'(cyc - 1), 32'(2 * n + n * (n - 1) / 2 + WB + 1));
    check_val({tag, " wen_count"}, 32'(nwen), 32'(WB));
    check_val({tag, " last_wen"}, 32'(last_wen), 32'(cyc - 1));
    check_val({tag, " stray_wr"}, 32'(bad_wr[g]), 32'd0);
    model(n, (g != 2), mn, mx, mi, mj, xi, xj);
    check_val({tag, " min_dist"}, 32'(mind_a[g]), 32'(mn));
    check_val({tag, " max_dist"}, 32'(maxd_a[g]), 32'(mx));
    check_val({tag, " min_idx"}, {16'd0, mi_a[g], mj_a[g]}, 32'((mi << 8) | mj));
    check_val({tag, " max_idx"}, {16'd0, xi_a[g], xj_a[g]}, 32'((xi << 8) | xj));
    check_val({tag, " mem_min"}, {16'd0, mem[g][RES], mem[g][RES + 1]}, 32'(mn));
    check_val({tag, " mem_max"}, {16'd0, mem[g][RES + 2], mem[g][RES + 3]}, 32'(mx));
`ifdef PAIR_IDX_WR_EN
    check_val({tag, " mem_idx"}, {mem[g][RES + 4], mem[g][RES + 5], mem[g][RES + 6], mem[g][RES + 7]},
              32'((mi << 24) | (mj << 16) | (xi << 8) | xj));
`endif
    start_s[g] = 1'b1;
    @(posedge clk); #1;
    check_val({tag, " done_drop"}, 32'(done_a[g]), 32'd0);
  endtask

  initial begin
    int nwen;
    rst = 1'b1;
    for (int g = 0; g < NI; g++) start_s[g] = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check_val("rst done", 32'(done_a[0]), 32'd0);
    check_val("rst busy", 32'(busy_a[0]), 32'd0);
    check_val("rst wen", 32'(wen_a[0]), 32'd0);
    check_val("rst addr_wdata", {16'd0, addr_a[0], wdata_a[0]}, 32'd0);
    check_val("rst min_dist", 32'(mind_a[0]), 32'h0000FFFF);
    check_val("rst max_dist", 32'(maxd_a[0]), 32'd0);
    check_val("rst idx", {mi_a[0], mj_a[0], xi_a[0], xj_a[0]}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    set4(16'd10, 16'hFFFB, 16'd100, 16'd7);
    run_check(1, "basic");
    set4(16'd0, 16'd5, 16'd10, 16'd15);
    run_check(1, "ties");
    set4(16'h8000, 16'h7FFF, 16'h0000, 16'h0000);
    run_check(1, "extreme_s");
    set4(16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF);
    run_check(2, "extreme_u");
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 4; i++) vals[i] = (r % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 12));
      run_check(1 + (r % 2), "rand4");
    end
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 32; i++) vals[i] = (i % 3 == 0) ? 16'($urandom_range(0, 40)) : 16'($urandom);
      run_check(0, "rand32");
    end

    // Reset partway through SCAN, then a clean relaunch.
    for (int i = 0; i < 32; i++) vals[i] = 16'($urandom);
    load_vals(0);
    launch(0);
    repeat (84) begin @(posedge clk); #1; end
    check_val("pre_rst busy", 32'(busy_a[0]), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("mid_rst busy", 32'(busy_a[0]), 32'd0);
    check_val("mid_rst done", 32'(done_a[0]), 32'd0);
    check_val("mid_rst min_dist", 32'(mind_a[0]), 32'h0000FFFF);
    nwen = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 2) rst = 1'b0;
      if (wen_a[0]) nwen++;
      @(posedge clk); #1;
    end
    check_val("mid_rst no_wen", 32'(nwen), 32'd0);
    check_val("mid_rst mem_untouched", {16'd0, mem[0][RES], mem[0][RES + 1]}, 32'h0000EEEE);
    for (int i = 0; i < 32; i++) vals[i] = 16'($urandom);
    run_check(0, "relaunch");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pair_dist_engine.md
Name: pair_dist_engine

Overview:
- Hardware successor to the software min/max-distance program.
- Reads N signed or unsigned W-bit values from byte-wide data memory, held as big-endian byte groups.
- Computes the minimum and maximum |a-b| over all unordered pairs, then writes both magnitudes back to data memory.
- Sits beside data_mem under top and follows the same start/done request-acknowledge convention.

Parameters:
- N, 32: number of values; legal range 2..256.
- W, 16: value width in bits; multiple of 8, range 8..32.
- SIGNED, 1: 1 = two's-complement operands, 0 = unsigned operands.
- AW, 8: memory address width.
- BASE_ADDR, 0: byte address of value 0; value i occupies bytes BASE_ADDR+i*(W/8) onward, MSB byte first.
- RES_ADDR, 66: min result bytes start here (MSB first); max result bytes start at RES_ADDR+W/8.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; high holds the block idle, a 1->0 transition launches a run.
- done  out  1  acknowledge; high from run completion until start returns high.
- busy  out  1  high during LOAD, SCAN and WRITE.
- mem_addr  out  AW  byte address to data memory.
- mem_rdata  in  8  read data; combinational, valid in the same cycle as mem_addr.
- mem_wdata  out  8  write data.
- mem_wen  out  1  write enable; the write occurs at the clk edge.
- min_dist, max_dist  out  W  result magnitudes.
- min_i, min_j, max_i, max_j  out  $clog2(N)  pair indices, with i<j.

Behaviour:
- Reset values: state=IDLE; done=0, busy=0, mem_wen=0, mem_addr=0, mem_wdata=0; min_dist=all ones, max_dist=0, all indices 0.
- IDLE: a run launches when start is sampled 0 after being sampled 1 in the previous cycle. On launch: min_dist<=all ones, max_dist<=0, indices<=0, go to LOAD.
- LOAD: one byte per cycle; N*(W/8) cycles. Bytes are shifted into an internal cache cache[0..N-1] of W bits each.
- SCAN: one pair per cycle, ordered j=0..N-2 and, for each j, k=j+1..N-1; N(N-1)/2 cycles.
- Distance: computed at W+1 bits (sign- or zero-extended per SIGNED), magnitude truncated to W bits. The magnitude is exact: the maximum is 2^W-1.
- Updates: if dist<min_dist, load min_dist and indices (j,k). If dist>max_dist, load max_dist and indices (j,k). Comparisons are strict, so on ties the first pair in scan order is kept.
- WRITE: 2*(W/8) cycles, mem_wen=1 each cycle. Writes the min bytes, MSB first, to RES_ADDR.., then the max bytes to RES_ADDR+W/8...
- DONE: done=1, busy=0. The block stays here until start is sampled 1, then returns to IDLE with done=0. Result ports hold their values until the next launch.
- Latency, launch edge to done=1: N*W/8 + N(N-1)/2 + 2*W/8 + 1 cycles. For defaults: 64+496+4+1 = 565.
- Abort: start sampled 1 during LOAD, SCAN or WRITE returns the block to IDLE next cycle. mem_wen drops immediately; done stays 0; partial memory writes are not undone.
- Reset mid-run: returns to IDLE next cycle with all reset values restored; no further mem_wen.
- Memory is never written outside WRITE. Address arithmetic wraps modulo 2^AW.

Optional Feature:
- PAIR_IDX_WR_EN defined: WRITE gains 4 extra cycles. min_i, min_j, max_i, max_j are written as one byte each, zero-extended, at RES_ADDR+2*(W/8) onward. Latency grows by 4.
- Not defined: no index bytes are written; index ports still function.

Test Plan:
- Defaults, N=4 override, values {10,-5,100,7} -> min_dist=3 (0,3), max_dist=105 (1,2); memory holds 0x0003 then 0x0069 at RES_ADDR.
- Ties, values {0,5,10,15} -> min_dist=5 with indices (0,1), first pair kept; max_dist=15 with indices (0,3).
- Extremes, SIGNED=1, {0x8000,0x7FFF,0x0000,0x0000} -> max_dist=65535 (0,1), min_dist=0 (2,3). Same data with SIGNED=0, using {0x8000,0x7FFF,0x0000,0xFFFF} -> min_dist=1 (0,1), max_dist=65535 (2,3).
- Full default run, N=32, random values -> results match a bench model at bytes 66..69. done rises exactly 565 cycles after the start falling edge. No mem_wen before WRITE.
- Reset asserted mid-SCAN -> next cycle busy=0, done=0, min_dist=0xFFFF, no writes. A relaunch then yields correct results.
- PAIR_IDX_WR_EN build, same data as the first scenario -> bytes at RES_ADDR+4..+7 = 0,3,1,2; done after the 4 extra write cycles.
